// File: rtl/spi_pkg.sv
// spi_pkg: state enum and mode constants shared by the spi_master files.
// Only SPI mode 0 (CPOL=0, CPHA=0) is supported.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD
   } spi_state_e;

   localparam int   SPI_BITS = 8;
   localparam int   CNT_W    = 8;
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: byte-level host handshake of spi_master.
// master = host issuing requests, slave = the spi_master block.
interface spi_master_if;
   import spi_pkg::*;

   logic [SPI_BITS-1:0] tx_data;
   logic                tx_start;
   logic                tx_ready;
   logic [SPI_BITS-1:0] rx_data;
   logic                rx_done;
   logic                busy;

   modport master (
      output tx_data,
      output tx_start,
      input  tx_ready,
      input  rx_data,
      input  rx_done,
      input  busy
   );

   modport slave (
      input  tx_data,
      input  tx_start,
      output tx_ready,
      output rx_data,
      output rx_done,
      output busy
   );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV phase counter for spi_master.
// tick marks the last cycle of a phase, pre_tick the one before it.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick,
   output logic pre_tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLK_DIV - 2);

   logic [CNT_W-1:0] cnt;

   assign tick     = en && (cnt == LAST);
   assign pre_tick = en && (cnt == PRE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI byte master (MSB first) with a valid/ready host port.
// Define SPI_MASTER_BURST_EN to chain bytes from the last HOLD cycle with cs kept low.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   spi_master_if.slave  bus,
   output logic         sclk,
   output logic         mosi,
   input  logic         miso,
   output logic         cs
);

   spi_state_e state, state_nx;

   logic [2:0]          bit_cnt;
   logic [SPI_BITS-2:0] tx_sh;
   logic [SPI_BITS-1:0] rx_sh;

   logic rdy_en;
   logic run;
   logic tick;
   logic pre_tick;
   logic last_bit;
   logic burst_ok;
   logic accept;
   logic hold_pre;
   logic load;
   logic go_hi;
   logic go_lo;
   logic fin;

   assign run = (state != IDLE);

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (run),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

`ifdef SPI_MASTER_BURST_EN
   assign burst_ok = (state == HOLD) && tick;
`else
   assign burst_ok = 1'b0;
`endif

   assign last_bit     = (bit_cnt == 3'(SPI_BITS - 1));
   assign hold_pre     = (state == HOLD) && pre_tick;
   // rdy_en keeps tx_ready low until the first edge after reset
   assign bus.tx_ready = rdy_en && ((state == IDLE) || burst_ok);
   assign accept       = bus.tx_start && bus.tx_ready;
   assign bus.busy     = run || accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      go_hi    = 1'b0;
      go_lo    = 1'b0;
      fin      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               load     = 1'b1;
               state_nx = SETUP;
            end
         end
         SETUP, LOW: begin
            if (tick) begin
               go_hi    = 1'b1;
               state_nx = HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               go_lo    = 1'b1;
               state_nx = last_bit ? HOLD : LOW;
            end
         end
         HOLD: begin
            if (tick) begin
               fin = 1'b1;
               if (accept) begin
                  load     = 1'b1;
                  state_nx = SETUP;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // rx_data lands one cycle early so it is valid while rx_done is high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs          <= 1'b1;
         sclk        <= SPI_CPOL;
         mosi        <= 1'b0;
         bit_cnt     <= '0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         rdy_en      <= 1'b0;
         bus.rx_data <= '0;
         bus.rx_done <= 1'b0;
      end else begin
         rdy_en      <= 1'b1;
         bus.rx_done <= hold_pre;
         if (hold_pre)
            bus.rx_data <= rx_sh;
         if (load) begin
            cs      <= 1'b0;
            mosi    <= bus.tx_data[SPI_BITS-1];
            tx_sh   <= bus.tx_data[SPI_BITS-2:0];
            bit_cnt <= '0;
         end else if (fin) begin
            cs <= 1'b1;
         end
         if (go_hi) begin
            sclk <= ~SPI_CPOL;
            if (!SPI_CPHA)
               rx_sh <= {rx_sh[SPI_BITS-2:0], miso};
         end
         if (go_lo) begin
            sclk <= SPI_CPOL;
            if (!last_bit) begin
               mosi    <= tx_sh[SPI_BITS-2];
               tx_sh   <= {tx_sh[SPI_BITS-3:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule
